imem_loader: RTL

- Byte-stream writer for the instruction memory; the write-side counterpart of the read-only instruction ROM.
- Accepts a framed byte stream (e.g. from a UART receiver): 16-bit word-count header, then payload bytes.
- Assembles payload bytes little-endian into Dbits-wide words and issues one write per word to a writable imem port.
- Holds the CPU in reset while loading.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream writer for the instruction memory; holds the CPU while loading.
// Optional payload checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    wr,
    output logic [$clog2(Nloc)-1:0] addr,
    output logic [Dbits-1:0]        din,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error
);

    localparam int BPW = Dbits / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_HDR_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam logic [2:0] S_CHECK  = 3'd7;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FIN = S_CHECK;
`else
    localparam logic [2:0] S_FIN = S_DONE;
`endif

    logic [2:0]    state;
    logic [15:0]   len;
    logic [BW-1:0] bcnt;
    logic          xfer;
    logic          last_byte;
    logic          last_word;
    logic [16:0]   hdr_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign last_byte = (bcnt == BW'(BPW - 1));
    assign last_word = (17'(addr) == (17'(len) - 17'd1));
    assign hdr_len   = {1'b0, rx_data, len[7:0]};

    always_comb begin
        rx_ready = 1'b0;
        wr       = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_HDR_LO, S_HDR_HI, S_DATA, S_CHECK: rx_ready = 1'b1;
            S_WRITE: wr = 1'b1;
            S_IDLE:  cpu_hold = 1'b0;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: cpu_hold = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            len   <= '0;
            bcnt  <= '0;
            addr  <= '0;
            din   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum  <= '0;
`endif
        end else begin
            case (state)
                // ERR is also left by start so a failed load can be retried
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state <= S_HDR_LO;
                        len   <= '0;
                        bcnt  <= '0;
                        addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum  <= '0;
`endif
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        state    <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        if (hdr_len > 17'(Nloc))
                            state <= S_ERR;
                        else if (hdr_len == 17'd0)
                            state <= S_FIN;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        din[{bcnt, 3'b000} +: 8] <= rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum <= xsum ^ rx_data;
`endif
                        if (last_byte) begin
                            bcnt  <= '0;
                            state <= S_WRITE;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                // addr stays on the last written word once the load ends
                S_WRITE: begin
                    if (last_word) begin
                        state <= S_FIN;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer)
                        state <= (rx_data == xsum) ? S_DONE : S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
